// File: rtl/aes_pkg.sv
// ============================================================================
// Module      : aes_pkg
// Description : AES tables, GF(2^8) helpers, inverse key step and FSM states
// Revision    : 1.0
// ============================================================================
`default_nettype none

package aes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Entry x sits at bit 2047-8x, i.e. {~x, 3'b111}.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

    // Walks the key schedule backwards: round key r -> round key r-1.
    function automatic logic [127:0] prev_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, v0, v1, v2, v3, rot;
        {w0, w1, w2, w3} = k;
        v3  = w3 ^ w2;
        v2  = w2 ^ w1;
        v1  = w1 ^ w0;
        rot = {v3[23:0], v3[31:24]};
        v0  = w0 ^ {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
                 ^ {rc, 24'h000000};
        return {v0, v1, v2, v3};
    endfunction

endpackage

`default_nettype wire

// File: rtl/inv_round.sv
// ============================================================================
// Module      : inv_round
// Description : One combinational AES inverse round; MixColumns skipped on last
// Revision    : 1.0
// ============================================================================
`default_nettype none

module inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] round_key_i,
    input  logic         last_i,
    output logic [127:0] state_o
);

    logic [127:0] w_sub;
    logic [127:0] w_ark;
    logic [127:0] w_mix;

    // InvShiftRows folded into the byte select: row r rotates right by r.
    for (genvar gi = 0; gi < 16; gi++) begin : g_byte
        localparam int ROW = gi % 4;
        localparam int COL = gi / 4;
        localparam int SRC = 4 * ((COL + 4 - ROW) % 4) + ROW;
        assign w_sub[127-8*gi -: 8] = inv_sbox(state_i[127-8*SRC -: 8]);
    end

    assign w_ark = w_sub ^ round_key_i;

    for (genvar gc = 0; gc < 4; gc++) begin : g_col
        assign w_mix[127-32*gc -: 32] = inv_mix_col(w_ark[127-32*gc -: 32]);
    end

    assign state_o = last_i ? w_ark : w_mix;

endmodule

`default_nettype wire

// File: rtl/inv_cipher.sv
// ============================================================================
// Module      : inv_cipher
// Description : Iterative AES-128 decryption, one inverse round per clock
// Revision    : 1.0
// ============================================================================
`default_nettype none

module inv_cipher
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] key_in,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out
);

    state_e       fsm_q, fsm_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] key_q, key_d;
    logic [127:0] dout_q, dout_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         vld_q, vld_d;

    logic         w_last;
    logic [127:0] w_round;

    assign w_last = (fsm_q == FINAL);

    inv_round u_round (
        .state_i     (blk_q),
        .round_key_i (key_q),
        .last_i      (w_last),
        .state_o     (w_round)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            fsm_q  <= IDLE;
            blk_q  <= '0;
            key_q  <= '0;
            dout_q <= '0;
            cnt_q  <= '0;
            vld_q  <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            blk_q  <= blk_d;
            key_q  <= key_d;
            dout_q <= dout_d;
            cnt_q  <= cnt_d;
            vld_q  <= vld_d;
        end
    end

    always_comb begin
        fsm_d  = fsm_q;
        blk_d  = blk_q;
        key_d  = key_q;
        dout_d = dout_q;
        cnt_d  = cnt_q;
        vld_d  = vld_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    blk_d = data_in ^ key_in;
                    key_d = prev_key(key_in, rcon(4'(NR)));
                    cnt_d = 4'(NR - 1);
                    fsm_d = ROUND;
                end
            end
            ROUND: begin
                blk_d = w_round;
                key_d = prev_key(key_q, rcon(cnt_q));
                cnt_d = cnt_q - 4'd1;
                // <=1 rather than ==1 keeps the counter from ever wrapping.
                if (cnt_q <= 4'd1) fsm_d = FINAL;
            end
            FINAL: begin
                dout_d = w_round;
                vld_d  = 1'b1;
                fsm_d  = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    vld_d = 1'b0;
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // Held low while reset is asserted so nothing is accepted in that cycle.
    assign in_ready  = rst && (fsm_q == IDLE);
    assign out_valid = vld_q;
    assign data_out  = dout_q;

endmodule

`default_nettype wire

// File: tb/tb_inv_cipher.sv
// ============================================================================
// Module      : tb_inv_cipher
// Description : Bench for inv_cipher; reference is a forward AES-128 encryptor
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_inv_cipher;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] key_in;
    logic [127:0] data_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_K0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    typedef struct {
        logic [127:0] ct;
        logic [127:0] key;
        logic [127:0] pt;
    } vec_t;

    vec_t       vt [10];
    logic [7:0] sb [256];

    inv_cipher #(.NR(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .key_in    (key_in),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] v;
        logic [7:0] p;
        for (int x = 0; x < 256; x++) begin
            v = 8'(x);
            p = 8'h01;
            if (x == 0) p = 8'h00;
            else for (int e = 0; e < 254; e++) p = gm(p, v);
            sb[x] = p ^ rotl(p, 1) ^ rotl(p, 2) ^ rotl(p, 3) ^ rotl(p, 4) ^ 8'h63;
        end
    endtask

    task automatic aes_enc(input logic [127:0] pt, input logic [127:0] k0,
                           output logic [127:0] ct, output logic [127:0] k10);
        logic [31:0] w [44];
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [31:0] tw;
        logic [7:0]  rc, a0, a1, a2, a3;
        for (int i = 0; i < 4; i++) w[i] = k0[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tw = w[i-1];
            if (i % 4 == 0) begin
                tw = {tw[23:0], tw[31:24]};
                tw = {sb[tw[31:24]], sb[tw[23:16]], sb[tw[15:8]], sb[tw[7:0]]} ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tw;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[4*(((i/4) + (i%4)) % 4) + i%4]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r < 10) begin
                    s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
                    s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
        k10 = {w[40], w[41], w[42], w[43]};
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({nm, " latency"}, 128'(n), 128'd10);
    endtask

    task automatic send(input logic [127:0] ct, input logic [127:0] k, input logic [127:0] exp,
                        input bit perturb, input string nm);
        check({nm, " in_ready"}, {127'b0, in_ready}, 128'd1);
        data_in  = ct;
        key_in   = k;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        if (perturb) begin
            data_in = ~ct;
            key_in  = k ^ {$urandom, $urandom, $urandom, $urandom};
        end
        wait_valid(nm);
        check({nm, " data"}, data_out, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({nm, " valid drop"}, {127'b0, out_valid}, 128'd0);
        check({nm, " ready back"}, {127'b0, in_ready}, 128'd1);
    endtask

    initial begin
        logic [127:0] pt, k0, ct, k10;
        int c1;

        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        key_in    = '0;

        build_sbox();
        aes_enc(C1_PT, C1_K0, ct, k10);
        check("model C.1 ct", ct, C1_CT);
        check("model C.1 k10", k10, C1_K10);

        vt[0] = '{C1_CT, C1_K10, C1_PT};
        vt[1] = '{B_CT, B_K10, B_PT};
        for (int i = 2; i < 10; i++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            k0 = {$urandom, $urandom, $urandom, $urandom};
            aes_enc(pt, k0, ct, k10);
            vt[i] = '{ct, k10, pt};
        end

        tick();
        tick();
        check("reset out_valid", {127'b0, out_valid}, 128'd0);
        check("reset data_out", data_out, 128'd0);
        check("reset in_ready", {127'b0, in_ready}, 128'd0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) send(vt[i].ct, vt[i].key, vt[i].pt, 1'b0, $sformatf("vec%0d", i));

        send(C1_CT, C1_K10, C1_PT, 1'b1, "input change");

        // Backpressure with a competing in_valid that must be ignored.
        data_in  = C1_CT;
        key_in   = C1_K10;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid("bp");
        data_in  = B_CT;
        key_in   = B_K10;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp hold valid", {127'b0, out_valid}, 128'd1);
            check("bp hold data", data_out, C1_PT);
            check("bp hold ready", {127'b0, in_ready}, 128'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp release valid", {127'b0, out_valid}, 128'd0);
        check("bp release ready", {127'b0, in_ready}, 128'd1);
        check("bp retain data", data_out, C1_PT);
        repeat (12) tick();
        check("bp no ghost block", {127'b0, out_valid}, 128'd0);

        // Reset in the middle of a block.
        data_in  = C1_CT;
        key_in   = C1_K10;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b0;
        tick();
        check("midrst out_valid", {127'b0, out_valid}, 128'd0);
        check("midrst data_out", data_out, 128'd0);
        check("midrst in_ready", {127'b0, in_ready}, 128'd0);
        rst = 1'b1;
        tick();
        check("midrst ready after", {127'b0, in_ready}, 128'd1);
        repeat (12) tick();
        check("midrst no output", {127'b0, out_valid}, 128'd0);
        send(C1_CT, C1_K10, C1_PT, 1'b0, "post reset");

        // Back-to-back with in_valid and out_ready held high.
        data_in   = C1_CT;
        key_in    = C1_K10;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        data_in = B_CT;
        key_in  = B_K10;
        wait_valid("b2b first");
        check("b2b first data", data_out, C1_PT);
        c1 = cyc;
        tick();
        check("b2b ready", {127'b0, in_ready}, 128'd1);
        tick();
        in_valid = 1'b0;
        wait_valid("b2b second");
        check("b2b second data", data_out, B_PT);
        check("b2b spacing", 128'(cyc - c1), 128'd12);
        tick();
        out_ready = 1'b0;
        check("b2b end valid", {127'b0, out_valid}, 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
